counter_overflow_multi: RTL and testbench

Multi-channel, parametrised limit counter for timeout and interval generation. Each of CH independent channels counts enabled clock cycles up to its own limit and then either halts (one-shot) or reloads and continues (auto-reload). Each channel raises a single-cycle pulse and a sticky, acknowledgeable overflow flag. A combined interrupt line lets a controller service all channels from one place.

---
 rtl/counter_overflow_multi_pkg.sv | 13 +
 rtl/counter_overflow_ch.sv | 79 +++++++
 rtl/counter_overflow_multi.sv | 42 ++++
 tb/tb_counter_overflow_multi.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_overflow_multi_pkg.sv
// Shared constants for the multi-channel limit counter: mode encodings and
// the per-channel state type.
package counter_overflow_multi_pkg;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } ch_state_t;

endpackage

// File: rtl/counter_overflow_ch.sv
// One limit-counter channel: RUN/HALT FSM, up-counter, pulse and sticky flag.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_RUN  | counting enabled cycles toward the limit
// ST_HALT | one-shot limit reached; count frozen until CLR or reset
module counter_overflow_ch
   import counter_overflow_multi_pkg::*;
#(
   parameter int COUNTER_BITS = 32
) (
   input  logic                    i_CLK,
   input  logic                    i_RST_N,
   input  logic                    i_EN,
   input  logic                    i_CLR,
   input  logic                    i_MODE,
   input  logic [COUNTER_BITS-1:0] i_LIM,
   input  logic                    i_ACK,
   output logic [COUNTER_BITS-1:0] o_COUNT,
   output logic                    o_PULSE,
   output logic                    o_OVERFLOW,
   output logic                    o_DONE
);

   ch_state_t               state_q, state_d;
   logic [COUNTER_BITS-1:0] count_q, count_d;
   logic                    pulse_q, pulse_d;
   logic                    ovf_q, ovf_d;
   logic [COUNTER_BITS-1:0] count_inc;
   logic                    active;
   logic                    hit;

   assign count_inc = count_q + {{(COUNTER_BITS-1){1'b0}}, 1'b1};
   assign active    = (state_q == ST_RUN) && i_EN && (i_LIM != '0);
   // >= rather than == so a limit lowered below the count still fires
   assign hit       = active && (count_inc >= i_LIM);

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q <= ST_RUN;
         count_q <= '0;
         pulse_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pulse_q <= pulse_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pulse_d = 1'b0;
      ovf_d   = i_ACK ? 1'b0 : ovf_q;
      if (i_CLR) begin
         state_d = ST_RUN;
         count_d = '0;
      end else if (hit) begin
         pulse_d = 1'b1;
         ovf_d   = 1'b1;
         if (i_MODE == MODE_RELOAD) begin
            count_d = '0;
         end else begin
            count_d = i_LIM;
            state_d = ST_HALT;
         end
      end else if (active) begin
         count_d = count_inc;
      end
   end

   assign o_COUNT    = count_q;
   assign o_PULSE    = pulse_q;
   assign o_OVERFLOW = ovf_q;
   assign o_DONE     = (state_q == ST_HALT);

endmodule

// File: rtl/counter_overflow_multi.sv
// CH independent limit counters with a combined overflow interrupt.
module counter_overflow_multi
   import counter_overflow_multi_pkg::*;
#(
   parameter int CH           = 4,
   parameter int COUNTER_BITS = 32
) (
   input  logic                       i_CLK,
   input  logic                       i_RST_N,
   input  logic [CH-1:0]              i_EN,
   input  logic [CH-1:0]              i_CLR,
   input  logic [CH-1:0]              i_MODE,
   input  logic [CH*COUNTER_BITS-1:0] i_LIM,
   input  logic [CH-1:0]              i_ACK,
   output logic [CH*COUNTER_BITS-1:0] o_COUNT,
   output logic [CH-1:0]              o_PULSE,
   output logic [CH-1:0]              o_OVERFLOW,
   output logic [CH-1:0]              o_DONE,
   output logic                       o_IRQ
);

   for (genvar k = 0; k < CH; k++) begin : g_ch
      counter_overflow_ch #(
         .COUNTER_BITS(COUNTER_BITS)
      ) u_ch (
         .i_CLK      (i_CLK),
         .i_RST_N    (i_RST_N),
         .i_EN       (i_EN[k]),
         .i_CLR      (i_CLR[k]),
         .i_MODE     (i_MODE[k]),
         .i_LIM      (i_LIM[k*COUNTER_BITS +: COUNTER_BITS]),
         .i_ACK      (i_ACK[k]),
         .o_COUNT    (o_COUNT[k*COUNTER_BITS +: COUNTER_BITS]),
         .o_PULSE    (o_PULSE[k]),
         .o_OVERFLOW (o_OVERFLOW[k]),
         .o_DONE     (o_DONE[k])
      );
   end

   assign o_IRQ = |o_OVERFLOW;

endmodule

// File: tb/tb_counter_overflow_multi.sv
// Directed bench for counter_overflow_multi at CH=4, COUNTER_BITS=4.
module tb_counter_overflow_multi;

   localparam int CH = 4;
   localparam int CB = 4;

   logic              clk;
   logic              rst_n;
   logic [CH-1:0]     en, clr, mode, ack;
   logic [CH*CB-1:0]  lim;
   logic [CH*CB-1:0]  count;
   logic [CH-1:0]     pulse, ovf, done;
   logic              irq;

   int checks   = 0;
   int failures = 0;

   counter_overflow_multi #(.CH(CH), .COUNTER_BITS(CB)) dut (
      .i_CLK      (clk),
      .i_RST_N    (rst_n),
      .i_EN       (en),
      .i_CLR      (clr),
      .i_MODE     (mode),
      .i_LIM      (lim),
      .i_ACK      (ack),
      .o_COUNT    (count),
      .o_PULSE    (pulse),
      .o_OVERFLOW (ovf),
      .o_DONE     (done),
      .o_IRQ      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = '0; clr = '0; mode = '0; ack = '0; lim = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({count, pulse, ovf, done, irq} !== '0) begin
         $display("FAIL reset_state got=%h exp=0", {count, pulse, ovf, done, irq});
         failures++;
      end
      rst_n = 1'b1;
      lim[3:0] = 4'd10; en = 4'b0001;
      repeat (5) step();
      checks++;
      if (count[3:0] !== 4'd5) begin
         $display("FAIL pre_reset_count got=%0d exp=5", count[3:0]);
         failures++;
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({count, pulse, ovf, done, irq} !== '0) begin
         $display("FAIL async_reset got=%h exp=0", {count, pulse, ovf, done, irq});
         failures++;
      end
      lim[3:0] = 4'd4;
      step();
      checks++;
      if (count[3:0] !== 4'd0) begin
         $display("FAIL held_in_reset got=%0d exp=0", count[3:0]);
         failures++;
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         checks++;
         if (count[3:0] !== 4'(i) || pulse[0] !== (i == 4) || done[0] !== (i == 4)) begin
            $display("FAIL oneshot_run i=%0d got cnt=%0d p=%b d=%b exp cnt=%0d p=%b d=%b",
                     i, count[3:0], pulse[0], done[0], i, (i == 4), (i == 4));
            failures++;
         end
      end
      checks++;
      if (ovf[0] !== 1'b1 || irq !== 1'b1) begin
         $display("FAIL oneshot_flag got ovf=%b irq=%b exp 1 1", ovf[0], irq);
         failures++;
      end
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (count[3:0] !== 4'd4 || pulse[0] !== 1'b0 || done[0] !== 1'b1) begin
            $display("FAIL halt_hold i=%0d got cnt=%0d p=%b d=%b exp cnt=4 p=0 d=1",
                     i, count[3:0], pulse[0], done[0]);
            failures++;
         end
      end
   endtask

   task automatic test_clr_hold();
      clr = 4'b0001;
      step();
      checks++;
      if (count[3:0] !== 4'd0 || done[0] !== 1'b0 || ovf[0] !== 1'b1 || pulse[0] !== 1'b0) begin
         $display("FAIL clr_in_halt got cnt=%0d d=%b o=%b p=%b exp cnt=0 d=0 o=1 p=0",
                  count[3:0], done[0], ovf[0], pulse[0]);
         failures++;
      end
      clr = '0;
      step();
      step();
      checks++;
      if (count[3:0] !== 4'd2) begin
         $display("FAIL resume_after_clr got=%0d exp=2", count[3:0]);
         failures++;
      end
      en = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (count[3:0] !== 4'd2) begin
            $display("FAIL en_low_hold i=%0d got=%0d exp=2", i, count[3:0]);
            failures++;
         end
      end
      en = 4'b0001;
      step();
      checks++;
      if (count[3:0] !== 4'd3) begin
         $display("FAIL en_resume got=%0d exp=3", count[3:0]);
         failures++;
      end
      en = '0; ack = 4'b0001;
      step();
      checks++;
      if (ovf[0] !== 1'b0 || irq !== 1'b0) begin
         $display("FAIL ack_clear got ovf=%b irq=%b exp 0 0", ovf[0], irq);
         failures++;
      end
      ack = '0;
   endtask

   task automatic test_reload();
      clr = 4'b0001;
      step();
      clr = '0; lim[3:0] = 4'd3; mode = 4'b0001; en = 4'b0001;
      for (int i = 1; i <= 6; i++) begin
         step();
         checks++;
         if (count[3:0] !== 4'(i % 3) || pulse[0] !== (i % 3 == 0) || ovf[0] !== (i >= 3)) begin
            $display("FAIL reload i=%0d got cnt=%0d p=%b o=%b exp cnt=%0d p=%b o=%b",
                     i, count[3:0], pulse[0], ovf[0], i % 3, (i % 3 == 0), (i >= 3));
            failures++;
         end
      end
      ack = 4'b0001;
      step();
      checks++;
      if (count[3:0] !== 4'd1 || ovf[0] !== 1'b0) begin
         $display("FAIL reload_ack got cnt=%0d o=%b exp cnt=1 o=0", count[3:0], ovf[0]);
         failures++;
      end
      ack = '0;
      step();
      step();
      checks++;
      if (count[3:0] !== 4'd0 || pulse[0] !== 1'b1 || ovf[0] !== 1'b1) begin
         $display("FAIL reload_rehit got cnt=%0d p=%b o=%b exp cnt=0 p=1 o=1",
                  count[3:0], pulse[0], ovf[0]);
         failures++;
      end
   endtask

   task automatic test_same_edge_ack();
      step();
      step();
      ack = 4'b0001;
      step();
      checks++;
      if (pulse[0] !== 1'b1 || ovf[0] !== 1'b1) begin
         $display("FAIL ack_vs_hit got p=%b o=%b exp p=1 o=1", pulse[0], ovf[0]);
         failures++;
      end
      step();
      checks++;
      if (count[3:0] !== 4'd1 || ovf[0] !== 1'b0) begin
         $display("FAIL ack_after_hit got cnt=%0d o=%b exp cnt=1 o=0", count[3:0], ovf[0]);
         failures++;
      end
      ack = '0;
   endtask

   task automatic test_limits();
      int npulse;
      clr = 4'b0001; ack = 4'b0001; mode = '0; lim[3:0] = 4'd10;
      step();
      clr = '0; ack = '0;
      repeat (6) step();
      checks++;
      if (count[3:0] !== 4'd6 || pulse[0] !== 1'b0) begin
         $display("FAIL lim10_run got cnt=%0d p=%b exp cnt=6 p=0", count[3:0], pulse[0]);
         failures++;
      end
      lim[3:0] = 4'd2;
      step();
      checks++;
      if (count[3:0] !== 4'd2 || pulse[0] !== 1'b1 || done[0] !== 1'b1) begin
         $display("FAIL lim_lowered got cnt=%0d p=%b d=%b exp cnt=2 p=1 d=1",
                  count[3:0], pulse[0], done[0]);
         failures++;
      end
      clr = 4'b0001; ack = 4'b0001; lim[3:0] = 4'd5;
      step();
      clr = '0; ack = '0;
      step();
      step();
      lim[3:0] = 4'd0;
      npulse = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (pulse[0] === 1'b1) npulse++;
         checks++;
         if (count[3:0] !== 4'd2) begin
            $display("FAIL lim0_freeze i=%0d got=%0d exp=2", i, count[3:0]);
            failures++;
         end
      end
      checks++;
      if (npulse != 0 || ovf[0] !== 1'b0 || done[0] !== 1'b0) begin
         $display("FAIL lim0_nohit got pulses=%0d o=%b d=%b exp 0 0 0", npulse, ovf[0], done[0]);
         failures++;
      end
   endtask

   task automatic test_multi();
      logic [CH-1:0]    ep, eo;
      logic [CH*CB-1:0] ec;
      en = '0; clr = 4'hF; ack = 4'hF; lim = '0;
      step();
      clr = '0; ack = '0;
      checks++;
      if (count !== '0 || ovf !== '0 || irq !== 1'b0) begin
         $display("FAIL multi_init got cnt=%h o=%b irq=%b exp 0 0 0", count, ovf, irq);
         failures++;
      end
      lim = {4'd7, 4'd7, 4'd1, 4'd15};
      mode = 4'b1110; en = 4'hF;
      for (int s = 1; s <= 15; s++) begin
         step();
         ep = {(s % 7 == 0), (s % 7 == 0), 1'b1, (s == 15)};
         eo = {(s >= 7), (s >= 7), 1'b1, (s >= 15)};
         ec = {4'(s % 7), 4'(s % 7), 4'd0, 4'(s)};
         checks++;
         if (pulse !== ep || ovf !== eo || count !== ec || irq !== 1'b1 ||
             done !== {3'b000, (s == 15)}) begin
            $display("FAIL multi s=%0d got p=%b o=%b c=%h d=%b irq=%b exp p=%b o=%b c=%h d=%b irq=1",
                     s, pulse, ovf, count, done, irq, ep, eo, ec, {3'b000, (s == 15)});
            failures++;
         end
      end
      en = '0; ack = 4'b1110;
      step();
      checks++;
      if (ovf !== 4'b0001 || irq !== 1'b1) begin
         $display("FAIL multi_partial_ack got o=%b irq=%b exp o=0001 irq=1", ovf, irq);
         failures++;
      end
      ack = 4'b0001;
      step();
      checks++;
      if (ovf !== 4'b0000 || irq !== 1'b0 || count[3:0] !== 4'd15 || done[0] !== 1'b1) begin
         $display("FAIL multi_final got o=%b irq=%b c0=%0d d0=%b exp o=0000 irq=0 c0=15 d0=1",
                  ovf, irq, count[3:0], done[0]);
         failures++;
      end
      ack = '0;
   endtask

   initial begin
      test_reset();
      test_clr_hold();
      test_reload();
      test_same_edge_ack();
      test_limits();
      test_multi();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
